vx_gbar_unit: RTL and testbench

//  Global barrier responder: the far end of the per-core gbar bus driven by each core's warp scheduler.

---
 rtl/vx_gbar_unit_pkg.sv | 43 ++++
 rtl/vx_gbar_rr_arbiter.sv | 56 +++++
 rtl/vx_gbar_unit.sv | 151 +++++++++++++++
 tb/tb_vx_gbar_unit.sv | 239 +++++++++++++++++++++++
 4 files changed

// File: rtl/vx_gbar_unit_pkg.sv
// vx_gbar_unit_pkg
//   Shared types and constants for the global barrier responder.
//   Holds the widths that size the gbar request/response buses, the request and
//   response records, the accept-outcome enum and a popcount helper.
//   This file has no ports; it is imported by vx_gbar_rr_arbiter and vx_gbar_unit.

package vx_gbar_unit_pkg;

  localparam int NUM_REQS     = 4;
  localparam int NUM_BARRIERS = 8;
  localparam int NB_WIDTH     = (NUM_BARRIERS > 1) ? $clog2(NUM_BARRIERS) : 1;
  localparam int NC_WIDTH     = (NUM_REQS > 1) ? $clog2(NUM_REQS) : 1;
  // One extra bit so that a full house of NUM_REQS arrivals does not wrap to 0.
  localparam int CNT_WIDTH    = NC_WIDTH + 1;

  typedef struct packed {
    logic [NB_WIDTH-1:0] id;
    logic [NC_WIDTH-1:0] size_m1;
    logic [NC_WIDTH-1:0] core_id;
  } gbar_req_t;

  typedef struct packed {
    logic [NB_WIDTH-1:0] id;
  } gbar_rsp_t;

  // What the accepted request does to its barrier this cycle.
  typedef enum logic [1:0] {
    ACC_NONE,
    ACC_HOLD,
    ACC_DUP,
    ACC_RELEASE
  } acc_kind_e;

  function automatic logic [CNT_WIDTH-1:0] popcount(input logic [NUM_REQS-1:0] bits);
    logic [CNT_WIDTH-1:0] n;
    n = '0;
    for (int i = 0; i < NUM_REQS; i++) begin
      n = n + CNT_WIDTH'(bits[i]);
    end
    return n;
  endfunction

endpackage

// File: rtl/vx_gbar_rr_arbiter.sv
// vx_gbar_rr_arbiter
//   N-way round-robin arbiter. The search for a requester starts at the
//   internal pointer; after a grant to index i the pointer moves to i+1
//   (mod N), and it holds when nothing is granted.
// Ports
//   clk, reset    clock and synchronous active-high reset (pointer -> 0)
//   requests      N request lines
//   grant_onehot  one-hot grant (or zero), combinational from requests
//   grant_index   index of the granted requester
//   grant_valid   a grant was made this cycle

module vx_gbar_rr_arbiter #(
  parameter int N  = 4,
  parameter int IW = (N > 1) ? $clog2(N) : 1
) (
  input  logic          clk,
  input  logic          reset,
  input  logic [N-1:0]  requests,
  output logic [N-1:0]  grant_onehot,
  output logic [IW-1:0] grant_index,
  output logic          grant_valid
);

  logic [IW-1:0] ptr;

  // Scan the requesters starting at ptr and take the first one found.
  always_comb begin
    logic [IW-1:0] idx;
    grant_onehot = '0;
    grant_index  = '0;
    grant_valid  = 1'b0;
    idx          = '0;
    for (int k = 0; k < N; k++) begin
      idx = IW'((int'(ptr) + k) % N);
      if (!grant_valid && requests[idx]) begin
        grant_valid       = 1'b1;
        grant_index       = idx;
        grant_onehot[idx] = 1'b1;
      end
    end
  end

  // Every grant is consumed by the requester, so the pointer advances on any grant.
  always_ff @(posedge clk) begin
    if (reset) begin
      ptr <= '0;
    end else if (grant_valid) begin
      if (grant_index == IW'(N - 1)) begin
        ptr <= '0;
      end else begin
        ptr <= grant_index + 1'b1;
      end
    end
  end

endmodule

// File: rtl/vx_gbar_unit.sv
// vx_gbar_unit
//   Global barrier responder shared by all cores of a cluster. Accepts at most
//   one arrival per cycle (round-robin across cores), tracks an arrival mask and
//   a latched participant count per barrier id, and broadcasts a one-cycle
//   release pulse once size_m1+1 distinct cores have arrived.
// Ports
//   clk, reset    clock and synchronous active-high reset
//   req_valid     per-core arrival request
//   req_id        per-core barrier id (packed, core i at [i*NB_WIDTH +: NB_WIDTH])
//   req_size_m1   per-core participant count minus one (packed likewise)
//   req_ready     per-core accept, one-hot or zero, 0 during reset
//   rsp_valid     release pulse, broadcast to all cores
//   rsp_id        id of the released barrier
//   err_dup       pulse: a core arrived again at a barrier it already holds
//   err_size      pulse: size_m1 differed from the barrier's latched size
//   busy          some barrier has arrivals or a release is being presented

module vx_gbar_unit
  import vx_gbar_unit_pkg::*;
(
  input  logic                         clk,
  input  logic                         reset,
  input  logic [NUM_REQS-1:0]          req_valid,
  input  logic [NUM_REQS*NB_WIDTH-1:0] req_id,
  input  logic [NUM_REQS*NC_WIDTH-1:0] req_size_m1,
  output logic [NUM_REQS-1:0]          req_ready,
  output logic                         rsp_valid,
  output logic [NB_WIDTH-1:0]          rsp_id,
  output logic                         err_dup,
  output logic                         err_size,
  output logic                         busy
);

  logic [NB_WIDTH-1:0]  id_arr   [NUM_REQS];
  logic [NC_WIDTH-1:0]  size_arr [NUM_REQS];
  logic [NUM_REQS-1:0]  arb_req;
  logic [NUM_REQS-1:0]  grant;
  logic [NC_WIDTH-1:0]  grant_idx;
  logic                 grant_valid;

  logic [NUM_REQS-1:0]  mask_q [NUM_BARRIERS];
  logic [NC_WIDTH-1:0]  size_q [NUM_BARRIERS];
  gbar_rsp_t            rsp_q;

  gbar_req_t            acc_req;
  logic [NUM_REQS-1:0]  mask_cur;
  logic [NUM_REQS-1:0]  mask_nxt;
  logic [NC_WIDTH-1:0]  size_eff;
  logic [CNT_WIDTH-1:0] arrive_cnt;
  logic                 first_arrival;
  logic                 size_mismatch;
  acc_kind_e            acc_kind;

  // Split the packed per-core buses, and check that a waiting requester
  // keeps its request stable until it is accepted.
  for (genvar i = 0; i < NUM_REQS; i++) begin : g_core
    assign id_arr[i]   = req_id[i*NB_WIDTH +: NB_WIDTH];
    assign size_arr[i] = req_size_m1[i*NC_WIDTH +: NC_WIDTH];

    a_hold_until_ready : assert property (
      @(posedge clk) disable iff (reset)
      (req_valid[i] && !req_ready[i]) |=>
        (req_valid[i] && $stable(id_arr[i]) && $stable(size_arr[i])));
  end

  // Nothing is granted while reset is held.
  assign arb_req   = reset ? '0 : req_valid;
  assign req_ready = grant;

  vx_gbar_rr_arbiter #(
    .N  (NUM_REQS),
    .IW (NC_WIDTH)
  ) u_arb (
    .clk          (clk),
    .reset        (reset),
    .requests     (arb_req),
    .grant_onehot (grant),
    .grant_index  (grant_idx),
    .grant_valid  (grant_valid)
  );

  // Classify the accepted request against the current state of its barrier.
  // The first arrival supplies the size; later arrivals are counted against
  // the latched size even if they disagree with it.
  always_comb begin
    acc_req.id      = id_arr[grant_idx];
    acc_req.size_m1 = size_arr[grant_idx];
    acc_req.core_id = grant_idx;
    mask_cur        = mask_q[acc_req.id];
    first_arrival   = (mask_cur == '0);
    size_eff        = first_arrival ? acc_req.size_m1 : size_q[acc_req.id];
    size_mismatch   = !first_arrival && (acc_req.size_m1 != size_q[acc_req.id]);
    mask_nxt        = mask_cur | (NUM_REQS'(1) << acc_req.core_id);
    arrive_cnt      = popcount(mask_nxt);
    acc_kind        = ACC_NONE;
    if (grant_valid) begin
      if (mask_cur[acc_req.core_id]) begin
        acc_kind = ACC_DUP;
      end else if (arrive_cnt == ({1'b0, size_eff} + CNT_WIDTH'(1))) begin
        acc_kind = ACC_RELEASE;
      end else begin
        acc_kind = ACC_HOLD;
      end
    end
  end

  // Barrier state, release pulse and error pulses. A release clears the mask
  // immediately, so the same id can start a new episode the very next cycle.
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int b = 0; b < NUM_BARRIERS; b++) begin
        mask_q[b] <= '0;
        size_q[b] <= '0;
      end
      rsp_valid <= 1'b0;
      rsp_q     <= '0;
      err_dup   <= 1'b0;
      err_size  <= 1'b0;
    end else begin
      rsp_valid <= 1'b0;
      err_dup   <= (acc_kind == ACC_DUP);
      err_size  <= grant_valid && size_mismatch;
      if (grant_valid && first_arrival) begin
        size_q[acc_req.id] <= acc_req.size_m1;
      end
      case (acc_kind)
        ACC_HOLD: begin
          mask_q[acc_req.id] <= mask_nxt;
        end
        ACC_RELEASE: begin
          mask_q[acc_req.id] <= '0;
          rsp_valid          <= 1'b1;
          rsp_q.id           <= acc_req.id;
        end
        default: begin
        end
      endcase
    end
  end

  assign rsp_id = rsp_q.id;

  // Busy looks only at registered state, never at the request inputs.
  always_comb begin
    busy = rsp_valid;
    for (int b = 0; b < NUM_BARRIERS; b++) begin
      busy = busy | (|mask_q[b]);
    end
  end

endmodule

// File: tb/tb_vx_gbar_unit.sv
// tb_vx_gbar_unit
//   Directed bench for vx_gbar_unit. Stimulus pushes the expected release and
//   error pulses (id and cycle) into queues; a negedge monitor pops and checks
//   them whenever the DUT presents a pulse, and flags pulses that are missing
//   or unexpected.

module tb_vx_gbar_unit;
  import vx_gbar_unit_pkg::*;

  logic                         clk = 1'b0;
  logic                         reset;
  logic [NUM_REQS-1:0]          req_valid;
  logic [NUM_REQS*NB_WIDTH-1:0] req_id;
  logic [NUM_REQS*NC_WIDTH-1:0] req_size_m1;
  logic [NUM_REQS-1:0]          req_ready;
  logic                         rsp_valid;
  logic [NB_WIDTH-1:0]          rsp_id;
  logic                         err_dup;
  logic                         err_size;
  logic                         busy;

  typedef struct {
    int id;
    int cyc;
  } exp_t;

  exp_t exp_rsp[$];
  int   exp_dup[$];
  int   exp_sz[$];
  exp_t e_mon;
  int   cyc   = 0;
  int   total = 0;
  int   bad   = 0;

  vx_gbar_unit dut (
    .clk         (clk),
    .reset       (reset),
    .req_valid   (req_valid),
    .req_id      (req_id),
    .req_size_m1 (req_size_m1),
    .req_ready   (req_ready),
    .rsp_valid   (rsp_valid),
    .rsp_id      (rsp_id),
    .err_dup     (err_dup),
    .err_size    (err_size),
    .busy        (busy)
  );

  always #5 clk = ~clk;

  // Cycle number = count of rising edges so far; read only at the falling edge.
  always @(posedge clk) cyc <= cyc + 1;

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] want);
    total++;
    if (act !== want) begin
      bad++;
      $display("[TB] FAIL %s: got %0d want %0d (cycle %0d)", name, act, want, cyc);
    end
  endtask

  // Drive one core's arrival, wait (bounded) for its grant, and record the
  // pulses this accept is expected to produce on the following cycle.
  task automatic applyStimulus(input int core, input int id, input int size_m1,
                               input bit rel, input bit dup, input bit szerr);
    int waited;
    waited = 0;
    req_valid[core] = 1'b1;
    req_id[core*NB_WIDTH +: NB_WIDTH]        = NB_WIDTH'(id);
    req_size_m1[core*NC_WIDTH +: NC_WIDTH]   = NC_WIDTH'(size_m1);
    @(negedge clk);
    while (!req_ready[core] && waited < 20) begin
      @(negedge clk);
      waited++;
    end
    checkOutput("ready", 32'(req_ready), 32'(1) << core);
    if (req_ready[core]) begin
      if (rel)   exp_rsp.push_back('{id, cyc + 1});
      if (dup)   exp_dup.push_back(cyc + 1);
      if (szerr) exp_sz.push_back(cyc + 1);
    end
    @(posedge clk);
    #1;
    req_valid[core] = 1'b0;
  endtask

  // Scoreboard monitor: compares every release/error pulse with the queues.
  always @(negedge clk) begin
    if (!reset) begin
      if (rsp_valid) begin
        if (exp_rsp.size() == 0) begin
          checkOutput("rsp_unexpected", 32'(rsp_valid), 0);
        end else begin
          e_mon = exp_rsp.pop_front();
          checkOutput("rsp_id", 32'(rsp_id), e_mon.id);
          checkOutput("rsp_cycle", cyc, e_mon.cyc);
        end
      end else if (exp_rsp.size() > 0 && exp_rsp[0].cyc <= cyc) begin
        checkOutput("rsp_missing", 32'(rsp_valid), 1);
        exp_rsp.delete(0);
      end

      if (err_dup) begin
        if (exp_dup.size() == 0) checkOutput("dup_unexpected", 32'(err_dup), 0);
        else checkOutput("dup_cycle", cyc, exp_dup.pop_front());
      end else if (exp_dup.size() > 0 && exp_dup[0] <= cyc) begin
        checkOutput("dup_missing", 32'(err_dup), 1);
        exp_dup.delete(0);
      end

      if (err_size) begin
        if (exp_sz.size() == 0) checkOutput("size_unexpected", 32'(err_size), 0);
        else checkOutput("size_cycle", cyc, exp_sz.pop_front());
      end else if (exp_sz.size() > 0 && exp_sz[0] <= cyc) begin
        checkOutput("size_missing", 32'(err_size), 1);
        exp_sz.delete(0);
      end
    end
  end

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: got timeout want finish");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    reset       = 1'b1;
    req_valid   = '0;
    req_id      = '0;
    req_size_m1 = '0;

    // Test 1: reset, a request during reset is not granted, then idle.
    repeat (2) @(posedge clk);
    #1 req_valid[0] = 1'b1;
    @(negedge clk);
    checkOutput("ready_in_reset", 32'(req_ready), 0);
    @(posedge clk);
    #1 req_valid = '0;
    @(posedge clk);
    #1 reset = 1'b0;
    repeat (10) begin
      @(negedge clk);
      checkOutput("idle_rsp_valid", 32'(rsp_valid), 0);
      checkOutput("idle_busy", 32'(busy), 0);
      checkOutput("idle_ready", 32'(req_ready), 0);
    end
    checkOutput("reset_rsp_id", 32'(rsp_id), 0);
    checkOutput("reset_err_dup", 32'(err_dup), 0);
    checkOutput("reset_err_size", 32'(err_size), 0);
    @(posedge clk);
    #1;

    // Test 2: id 3, four participants arriving one per cycle.
    applyStimulus(0, 3, 3, 0, 0, 0);
    applyStimulus(1, 3, 3, 0, 0, 0);
    applyStimulus(2, 3, 3, 0, 0, 0);
    applyStimulus(3, 3, 3, 1, 0, 0);
    @(negedge clk);
    checkOutput("t2_busy_during_rsp", 32'(busy), 1);
    @(negedge clk);
    checkOutput("t2_busy_after", 32'(busy), 0);
    @(posedge clk);
    #1;

    // Test 3: all cores request id 1 together; grants follow 0,1,2,3.
    for (int i = 0; i < NUM_REQS; i++) begin
      req_valid[i] = 1'b1;
      req_id[i*NB_WIDTH +: NB_WIDTH]      = NB_WIDTH'(1);
      req_size_m1[i*NC_WIDTH +: NC_WIDTH] = NC_WIDTH'(3);
    end
    for (int g = 0; g < NUM_REQS; g++) begin
      @(negedge clk);
      checkOutput("t3_rr_grant", 32'(req_ready), 32'(1) << g);
      if (g == NUM_REQS - 1) exp_rsp.push_back('{1, cyc + 1});
      @(posedge clk);
      #1 req_valid[g] = 1'b0;
    end
    // Pointer wrapped to core 0: with cores 0 and 3 waiting, 0 goes first.
    req_valid[0] = 1'b1; req_id[0 +: NB_WIDTH] = NB_WIDTH'(6); req_size_m1[0 +: NC_WIDTH] = NC_WIDTH'(1);
    req_valid[3] = 1'b1; req_id[3*NB_WIDTH +: NB_WIDTH] = NB_WIDTH'(6);
    req_size_m1[3*NC_WIDTH +: NC_WIDTH] = NC_WIDTH'(1);
    @(negedge clk);
    checkOutput("t3_wrap_grant0", 32'(req_ready), 32'h1);
    @(posedge clk);
    #1 req_valid[0] = 1'b0;
    @(negedge clk);
    checkOutput("t3_wrap_grant3", 32'(req_ready), 32'h8);
    exp_rsp.push_back('{6, cyc + 1});
    @(posedge clk);
    #1 req_valid[3] = 1'b0;

    // Test 4: duplicate arrival is flagged and not counted.
    applyStimulus(2, 2, 1, 0, 0, 0);
    applyStimulus(2, 2, 1, 0, 1, 0);
    @(negedge clk);
    checkOutput("t4_busy_pending", 32'(busy), 1);
    @(posedge clk);
    #1;
    applyStimulus(0, 2, 1, 1, 0, 0);

    // Test 5: two barriers interleaved, then a single-participant barrier.
    applyStimulus(0, 0, 1, 0, 0, 0);
    applyStimulus(1, 5, 2, 0, 0, 0);
    applyStimulus(1, 0, 1, 1, 0, 0);
    applyStimulus(2, 5, 2, 0, 0, 0);
    applyStimulus(3, 5, 2, 1, 0, 0);
    applyStimulus(2, 7, 0, 1, 0, 0);

    // Reuse: same id accepted in the cycle its release is presented.
    applyStimulus(0, 3, 0, 1, 0, 0);
    applyStimulus(1, 3, 0, 1, 0, 0);

    // Test 6: reset discards a pending arrival; new episode latches size 1.
    applyStimulus(0, 4, 3, 0, 0, 0);
    @(negedge clk);
    checkOutput("t6_busy_before_reset", 32'(busy), 1);
    reset = 1'b1;
    @(posedge clk);
    #1 reset = 1'b0;
    @(negedge clk);
    checkOutput("t6_busy_after_reset", 32'(busy), 0);
    repeat (3) @(posedge clk);
    #1;
    applyStimulus(1, 4, 1, 0, 0, 0);
    applyStimulus(2, 4, 2, 1, 0, 1);

    repeat (5) @(posedge clk);
    @(negedge clk);
    checkOutput("final_busy", 32'(busy), 0);
    checkOutput("rsp_leftover", exp_rsp.size(), 0);
    checkOutput("dup_leftover", exp_dup.size(), 0);
    checkOutput("size_leftover", exp_sz.size(), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
